// File: rtl/decode_stage.sv
// TINY pipeline instruction-decode stage: register file, early branch/jump resolution,
// hazard detection and the ID/EX pipeline register feeding execute.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inInst,
    input  logic [31:0] inNPC,
    input  logic        inValid,
    input  logic        wbEn,
    input  logic [4:0]  wbAddr,
    input  logic [31:0] wbData,
    input  logic [4:0]  memDest,
    input  logic        memRegWrite,
    output logic        stall,
    output logic        isBranchTaken,
    output logic [31:0] branchPC,
    output logic        flush,
    output logic        exValid,
    output logic        exRegWrite,
    output logic        exMemRead,
    output logic        exMemWrite,
    output logic        exALUSrc,
    output logic [2:0]  exALUOp,
    output logic [31:0] exA,
    output logic [31:0] exB,
    output logic [31:0] exImm,
    output logic [31:0] exNPC,
    output logic [4:0]  exRs,
    output logic [4:0]  exRt,
    output logic [4:0]  exDest,
    output logic        illegal
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Instruction fields
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [25:0] w_target;

    assign w_op     = inInst[31:26];
    assign w_rs     = inInst[25:21];
    assign w_rt     = inInst[20:16];
    assign w_rd     = inInst[15:11];
    assign w_funct  = inInst[5:0];
    assign w_imm    = inInst[15:0];
    assign w_target = inInst[25:0];

    // Decoded control
    logic    w_known;
    logic    w_is_branch;
    logic    w_is_beq;
    logic    w_is_j;
    logic    w_uses_rs;
    logic    w_uses_rt;
    logic    w_reg_write;
    logic    w_mem_read;
    logic    w_mem_write;
    logic    w_alu_src;
    alu_op_e w_alu_op;
    logic [4:0] w_dest;

    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        w_known     = 1'b0;
        w_is_branch = 1'b0;
        w_is_beq    = 1'b0;
        w_is_j      = 1'b0;
        w_uses_rs   = 1'b0;
        w_uses_rt   = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_alu_src   = 1'b0;
        w_alu_op    = ALU_ADD;
        w_dest      = 5'd0;
        case (w_op)
            OP_RTYPE: begin
                w_uses_rs   = 1'b1;
                w_uses_rt   = 1'b1;
                w_dest      = w_rd;
                w_reg_write = 1'b1;
                w_known     = 1'b1;
                case (w_funct)
                    FN_ADD:  w_alu_op = ALU_ADD;
                    FN_SUB:  w_alu_op = ALU_SUB;
                    FN_AND:  w_alu_op = ALU_AND;
                    FN_OR:   w_alu_op = ALU_OR;
                    FN_SLT:  w_alu_op = ALU_SLT;
                    default: w_known  = 1'b0;
                endcase
            end
            OP_ADDI: begin
                w_known     = 1'b1;
                w_uses_rs   = 1'b1;
                w_dest      = w_rt;
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            OP_LW: begin
                w_known     = 1'b1;
                w_uses_rs   = 1'b1;
                w_dest      = w_rt;
                w_reg_write = 1'b1;
                w_mem_read  = 1'b1;
                w_alu_src   = 1'b1;
            end
            OP_SW: begin
                w_known     = 1'b1;
                w_uses_rs   = 1'b1;
                w_uses_rt   = 1'b1;
                w_mem_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                w_known     = 1'b1;
                w_uses_rs   = 1'b1;
                w_uses_rt   = 1'b1;
                w_is_branch = 1'b1;
                w_is_beq    = (w_op == OP_BEQ);
            end
            OP_J: begin
                w_known = 1'b1;
                w_is_j  = 1'b1;
            end
            default: w_known = 1'b0;
        endcase
    end

    // Register file
    logic [31:0] r_regs [32];

    // NOTE: the register file is reset because the architecture requires all registers to read 0 after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wbEn && (wbAddr != 5'd0)) begin
            r_regs[wbAddr] <= wbData;
        end
    end

    // Reads see a same-cycle write-back so decode never needs a WB->ID forward
    logic [31:0] w_a;
    logic [31:0] w_b;

    assign w_a = (w_rs == 5'd0)                ? 32'd0  :
                 (wbEn && (wbAddr == w_rs))    ? wbData : r_regs[w_rs];
    assign w_b = (w_rt == 5'd0)                ? 32'd0  :
                 (wbEn && (wbAddr == w_rt))    ? wbData : r_regs[w_rt];

    // Hazard detection
    logic w_rs_hits_ex;
    logic w_rt_hits_ex;
    logic w_load_use;
    logic w_br_ex;
    logic w_br_mem;

    assign w_rs_hits_ex = w_uses_rs && (w_rs != 5'd0) && (w_rs == exDest);
    assign w_rt_hits_ex = w_uses_rt && (w_rt != 5'd0) && (w_rt == exDest);

    assign w_load_use = exValid && exMemRead && (exDest != 5'd0) && (w_rs_hits_ex || w_rt_hits_ex);
    assign w_br_ex    = w_is_branch && exRegWrite && (w_rs_hits_ex || w_rt_hits_ex);
    assign w_br_mem   = w_is_branch && memRegWrite &&
                        (((w_rs != 5'd0) && (w_rs == memDest)) ||
                         ((w_rt != 5'd0) && (w_rt == memDest)));

    assign stall = inValid && (w_load_use || w_br_ex || w_br_mem);

    // Branch / jump resolution
    logic        w_equal;
    logic        w_cond;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;

    assign w_equal     = (w_a == w_b);
    assign w_cond      = w_is_j || (w_is_branch && (w_is_beq ? w_equal : !w_equal));
    assign w_br_target = inNPC + {{14{w_imm[15]}}, w_imm, 2'b00};
    assign w_j_target  = {inNPC[31:28], w_target, 2'b00};

    assign isBranchTaken = inValid && !stall && w_cond;
    assign flush         = isBranchTaken;
    assign branchPC      = w_is_j ? w_j_target : w_br_target;

    // ID/EX pipeline register
    logic        w_bubble;
    logic        r_valid;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_alu_src;
    logic [2:0]  r_alu_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_imm;
    logic [31:0] r_npc;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic [4:0]  r_dest;
    logic        r_illegal;

    assign w_bubble = stall || !inValid || !w_known || w_is_branch || w_is_j;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_alu_src   <= 1'b0;
            r_alu_op    <= 3'd0;
            r_a         <= '0;
            r_b         <= '0;
            r_imm       <= '0;
            r_npc       <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_dest      <= '0;
        end else if (w_bubble) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_alu_src   <= 1'b0;
            r_alu_op    <= 3'd0;
            r_a         <= '0;
            r_b         <= '0;
            r_imm       <= '0;
            r_npc       <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_dest      <= '0;
        end else begin
            r_valid     <= 1'b1;
            r_reg_write <= w_reg_write;
            r_mem_read  <= w_mem_read;
            r_mem_write <= w_mem_write;
            r_alu_src   <= w_alu_src;
            r_alu_op    <= w_alu_op;
            r_a         <= w_a;
            r_b         <= w_b;
            r_imm       <= {{16{w_imm[15]}}, w_imm};
            r_npc       <= inNPC;
            r_rs        <= w_rs;
            r_rt        <= w_rt;
            r_dest      <= w_dest;
        end
    end

    // Sticky until reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_illegal <= 1'b0;
        end else if (inValid && !w_known) begin
            r_illegal <= 1'b1;
        end
    end

    assign exValid    = r_valid;
    assign exRegWrite = r_reg_write;
    assign exMemRead  = r_mem_read;
    assign exMemWrite = r_mem_write;
    assign exALUSrc   = r_alu_src;
    assign exALUOp    = r_alu_op;
    assign exA        = r_a;
    assign exB        = r_b;
    assign exImm      = r_imm;
    assign exNPC      = r_npc;
    assign exRs       = r_rs;
    assign exRt       = r_rt;
    assign exDest     = r_dest;
    assign illegal    = r_illegal;

endmodule
